image_buffer_loader: RTL and testbench

- Sits directly downstream of the UART router's image channel.
- Consumes the 784 pixel bytes plus the 0x66 0xBB trailer. The router strips the 0xBB 0x66 header and forwards everything else.
- Writes pixels into a two-bank (ping-pong) pixel RAM so that inference can read one bank while the next image fills the other.
- Validates the trailer, swaps banks when inference is idle, and pulses a start strobe to the inference engine.

---
 rtl/uart_proto_pkg.sv | 13 +
 rtl/image_buffer_loader_if.sv | 17 +
 rtl/image_buffer_loader_ram.sv | 19 +
 rtl/image_buffer_loader.sv | 109 ++++++++++
 tb/tb_image_buffer_loader.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_proto_pkg.sv
// uart_proto_pkg: shared UART protocol markers, sizes and the image loader state encoding.
package uart_proto_pkg;
    localparam logic [7:0] MARK_AA = 8'hAA;
    localparam logic [7:0] MARK_55 = 8'h55;
    localparam logic [7:0] MARK_BB = 8'hBB;
    localparam logic [7:0] MARK_66 = 8'h66;
    localparam logic [7:0] MARK_CC = 8'hCC;
    localparam logic [7:0] MARK_CD = 8'hCD;
    localparam int IMAGE_SIZE  = 784;
    localparam int WEIGHT_SIZE = 7880;
    localparam int ADDR_W      = 10;
    typedef enum logic [2:0] {LD_IDLE, LD_LOAD, LD_TRAIL1, LD_TRAIL2, LD_DRAIN} loader_state_t;
endpackage

// File: rtl/image_buffer_loader_if.sv
// image_buffer_loader_if: router byte stream plus inference-side read/control signals.
interface image_buffer_loader_if #(parameter int ADDR_W = uart_proto_pkg::ADDR_W);
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              infer_busy;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              rd_bank;
    logic              image_valid;
    logic              image_start;
    logic              load_error;
    logic              loading;
    modport master(output rx_data, rx_ready, infer_busy, rd_addr,
                   input rd_data, rd_bank, image_valid, image_start, load_error, loading);
    modport slave(input rx_data, rx_ready, infer_busy, rd_addr,
                  output rd_data, rd_bank, image_valid, image_start, load_error, loading);
endinterface

// File: rtl/image_buffer_loader_ram.sv
// image_bank_ram: two-bank pixel store, bank select in the address MSB, registered read port.
module image_bank_ram
    import uart_proto_pkg::*;
#(
    parameter int AW = ADDR_W + 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);
    logic [7:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/image_buffer_loader.sv
// image_buffer_loader: fills the idle bank of a ping-pong pixel RAM from the router image
// channel, validates the 0x66 0xBB trailer, then swaps banks and starts inference.
module image_buffer_loader
    import uart_proto_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10_000_000,
    parameter int DRAIN_MAX      = 796
) (
    input logic                  clk,
    input logic                  rst,
    image_buffer_loader_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    loader_state_t     state, state_n;
    logic [ADDR_W-1:0] count, count_n;
    logic [7:0]        prev, prev_n;
    logic [TW-1:0]     tmo;
    logic              pend, pend_n, err_n, to_drain, commit, tmo_hit, we, oor, rd_bank_n;
    logic [7:0]        ram_q;

    assign commit    = pend & ~bus.infer_busy;
    assign tmo_hit   = tmo == TW'(TIMEOUT_CYCLES - 1);
    assign rd_bank_n = bus.rd_bank ^ commit;
    assign we        = bus.rx_ready & ((state == LD_IDLE & ~pend) | state == LD_LOAD);
    assign bus.loading = state != LD_IDLE;
    assign bus.rd_data = oor ? 8'h00 : ram_q;

    // Read from the post-swap bank so the new image is readable as image_start rises.
    image_bank_ram u_ram (
        .clk    (clk),
        .we     (we),
        .wr_addr({~bus.rd_bank, state == LD_IDLE ? '0 : count}),
        .wr_data(bus.rx_data),
        .rd_addr({rd_bank_n, bus.rd_addr}),
        .rd_data(ram_q)
    );

    always_comb begin
        state_n  = state;
        count_n  = count;
        prev_n   = prev;
        pend_n   = commit ? 1'b0 : pend;
        err_n    = 1'b0;
        to_drain = 1'b0;
        if (bus.rx_ready) begin
            case (state)
                LD_IDLE: begin
                    to_drain = pend;
                    state_n  = pend ? LD_DRAIN : LD_LOAD;
                    count_n  = ADDR_W'(1);
                end
                LD_LOAD: begin
                    count_n = count + 1'b1;
                    state_n = count == ADDR_W'(IMAGE_SIZE - 1) ? LD_TRAIL1 : LD_LOAD;
                end
                LD_TRAIL1: begin
                    to_drain = bus.rx_data != MARK_66;
                    state_n  = LD_TRAIL2;
                end
                LD_TRAIL2: begin
                    to_drain = bus.rx_data != MARK_BB;
                    pend_n   = !to_drain;
                    state_n  = LD_IDLE;
                end
                default: begin
                    count_n = count + 1'b1;
                    prev_n  = bus.rx_data;
                    state_n = (prev == MARK_66 && bus.rx_data == MARK_BB) ||
                              count == ADDR_W'(DRAIN_MAX - 1) ? LD_IDLE : LD_DRAIN;
                end
            endcase
            if (to_drain) begin
                state_n = LD_DRAIN;
                err_n   = 1'b1;
                count_n = ADDR_W'(1);
                prev_n  = bus.rx_data;
            end
        end else if (tmo_hit && state != LD_IDLE) begin
            state_n = LD_IDLE;
            err_n   = state != LD_DRAIN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= LD_IDLE;
            count           <= '0;
            prev            <= '0;
            tmo             <= '0;
            pend            <= 1'b0;
            oor             <= 1'b1;
            bus.rd_bank     <= 1'b0;
            bus.image_valid <= 1'b0;
            bus.image_start <= 1'b0;
            bus.load_error  <= 1'b0;
        end else begin
            state           <= state_n;
            count           <= count_n;
            prev            <= prev_n;
            tmo             <= (bus.rx_ready || state == LD_IDLE) ? '0 : tmo + 1'b1;
            pend            <= pend_n;
            oor             <= bus.rd_addr >= ADDR_W'(IMAGE_SIZE);
            bus.rd_bank     <= rd_bank_n;
            bus.image_valid <= bus.image_valid | commit;
            bus.image_start <= commit;
            bus.load_error  <= err_n;
        end
    end
endmodule

// File: tb/tb_image_buffer_loader.sv
// tb_image_buffer_loader: directed scenarios plus randomized byte streams, checked every
// cycle against a byte-level reference model of the loader.
module tb_image_buffer_loader;
    import uart_proto_pkg::*;
    localparam int TMO = 1000;
    localparam int DMAX = 796;
    localparam int M_IDLE = 0, M_LOAD = 1, M_T1 = 2, M_T2 = 3, M_DRAIN = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    image_buffer_loader_if bus();
    image_buffer_loader #(.TIMEOUT_CYCLES(TMO), .DRAIN_MAX(DMAX)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [7:0] mem [2][IMAGE_SIZE];
    bit known [2][IMAGE_SIZE];
    int m_mode, m_idx, m_dn, m_idle;
    logic [7:0] m_prev, e_rd;
    bit m_rb, m_pend, m_valid, e_err, e_start, rd_known;
    bit g_busy, g_rand_busy;
    logic [7:0] pix [IMAGE_SIZE];
    bit saved_bank;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rand_addr();
        return int'($urandom_range(0, 1023));
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_rb = 0; m_pend = 0; m_valid = 0; m_idle = 0;
        e_err = 0; e_start = 0; e_rd = 0; rd_known = 1;
    endtask

    // One clock edge of the reference: byte handling first, then any pending bank swap.
    task automatic model_edge(input bit rdy, input logic [7:0] b, input bit busy, input int addr);
        bit pre = m_pend;
        bit drain = 0;
        e_err = 0; e_start = 0;
        if (rdy) begin
            m_idle = 0;
            case (m_mode)
                M_IDLE: if (m_pend) drain = 1;
                        else begin
                            mem[!m_rb][0] = b; known[!m_rb][0] = 1; m_idx = 1; m_mode = M_LOAD;
                        end
                M_LOAD: begin
                    mem[!m_rb][m_idx] = b; known[!m_rb][m_idx] = 1; m_idx++;
                    if (m_idx == IMAGE_SIZE) m_mode = M_T1;
                end
                M_T1: if (b == 8'h66) m_mode = M_T2; else drain = 1;
                M_T2: if (b == 8'hBB) begin m_pend = 1; m_mode = M_IDLE; end else drain = 1;
                default: begin
                    if (m_prev == 8'h66 && b == 8'hBB) m_mode = M_IDLE;
                    else begin
                        m_dn++;
                        if (m_dn == DMAX) m_mode = M_IDLE;
                    end
                    m_prev = b;
                end
            endcase
            if (drain) begin e_err = 1; m_mode = M_DRAIN; m_dn = 1; m_prev = b; end
        end else if (m_mode == M_IDLE) m_idle = 0;
        else begin
            m_idle++;
            if (m_idle == TMO) begin e_err = m_mode != M_DRAIN; m_mode = M_IDLE; m_idle = 0; end
        end
        if (pre && !busy) begin m_rb = !m_rb; m_valid = 1; e_start = 1; m_pend = 0; end
        rd_known = addr >= IMAGE_SIZE || known[m_rb][addr];
        e_rd = addr >= IMAGE_SIZE ? 8'h00 : mem[m_rb][addr];
    endtask

    task automatic tick(input bit rdy, input logic [7:0] b, input int addr);
        if (g_rand_busy && $urandom_range(0, 63) == 0) g_busy = !g_busy;
        bus.rx_ready = rdy; bus.rx_data = b; bus.infer_busy = g_busy;
        bus.rd_addr = ADDR_W'(addr);
        @(posedge clk);
        model_edge(rdy, b, g_busy, addr);
        #1;
        check("load_error", bus.load_error, e_err);
        check("image_start", bus.image_start, e_start);
        check("rd_bank", bus.rd_bank, m_rb);
        check("image_valid", bus.image_valid, m_valid);
        check("loading", bus.loading, m_mode != M_IDLE);
        if (rd_known) check("rd_data", bus.rd_data, e_rd);
        bus.rx_ready = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 8'h00, rand_addr());
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        tick(1, b, rand_addr());
        idle(gap);
    endtask

    task automatic send_pixels(input int n);
        for (int i = 0; i < n; i++) send(pix[i], int'($urandom_range(0, 1)));
    endtask

    task automatic fill_random();
        for (int i = 0; i < IMAGE_SIZE; i++) pix[i] = 8'($urandom);
    endtask

    initial begin
        bus.rx_ready = 0; bus.rx_data = 0; bus.infer_busy = 0; bus.rd_addr = '0;
        g_busy = 0; g_rand_busy = 0;
        model_reset();
        #12;
        check("rst_rd_bank", bus.rd_bank, 0);
        check("rst_valid", bus.image_valid, 0);
        check("rst_start", bus.image_start, 0);
        check("rst_err", bus.load_error, 0);
        check("rst_loading", bus.loading, 0);
        check("rst_rd_data", bus.rd_data, 0);
        @(negedge clk) rst = 1;

        for (int i = 0; i < IMAGE_SIZE; i++) pix[i] = 8'(i);
        send_pixels(IMAGE_SIZE);
        send(8'h66, 0);
        send(8'hBB, 0);
        check("start_c1", bus.image_start, 0);
        tick(0, 8'h00, 300);
        check("start_c2", bus.image_start, 1);
        check("norm_bank", bus.rd_bank, 1);
        check("norm_valid", bus.image_valid, 1);
        check("px300", bus.rd_data, 8'h2C);
        idle(3);

        for (int i = 0; i < IMAGE_SIZE; i++) pix[i] = 8'h00;
        pix[10] = 8'h66; pix[11] = 8'hBB;
        send_pixels(IMAGE_SIZE);
        send(8'h66, 0);
        send(8'hBB, 0);
        tick(0, 8'h00, 11);
        check("emb_start", bus.image_start, 1);
        check("emb_bank", bus.rd_bank, 0);
        check("emb_px11", bus.rd_data, 8'hBB);
        idle(3);

        fill_random();
        saved_bank = bus.rd_bank;
        send_pixels(IMAGE_SIZE);
        send(8'h66, 0);
        send(8'h00, 0);
        check("bad_err", bus.load_error, 1);
        idle(1);
        check("bad_err_once", bus.load_error, 0);
        send(8'h12, 1); send(8'h66, 1); send(8'hBB, 1);
        idle(4);
        check("bad_bank", bus.rd_bank, saved_bank);
        check("bad_idle", bus.loading, 0);

        g_busy = 1;
        for (int i = 0; i < IMAGE_SIZE; i++) pix[i] = 8'(i);
        send_pixels(IMAGE_SIZE);
        send(8'h66, 0); send(8'hBB, 0);
        idle(20);
        check("hold_no_start", bus.image_start, 0);
        send(8'h40, 0);
        check("ovr_err", bus.load_error, 1);
        check("ovr_drain", bus.loading, 1);
        g_busy = 0;
        tick(0, 8'h00, 5);
        check("hold_start", bus.image_start, 1);
        check("hold_bank", bus.rd_bank, 1);
        check("hold_px5", bus.rd_data, 8'h05);
        send(8'h66, 1); send(8'hBB, 1);
        idle(3);

        for (int i = 0; i < 100; i++) send(8'($urandom), 0);
        idle(TMO - 1);
        check("tmo_early", bus.load_error, 0);
        idle(1);
        check("tmo_err", bus.load_error, 1);
        check("tmo_idle", bus.loading, 0);
        fill_random();
        send_pixels(IMAGE_SIZE);
        send(8'h66, 0); send(8'hBB, 0);
        idle(1);
        check("tmo_start", bus.image_start, 1);
        check("tmo_bank", bus.rd_bank, 0);
        idle(3);

        fill_random();
        send_pixels(400);
        rst = 0;
        #1;
        check("rst_mid_bank", bus.rd_bank, 0);
        check("rst_mid_valid", bus.image_valid, 0);
        check("rst_mid_loading", bus.loading, 0);
        check("rst_mid_rd", bus.rd_data, 0);
        check("rst_mid_err", bus.load_error, 0);
        model_reset();
        @(negedge clk) rst = 1;
        fill_random();
        send_pixels(IMAGE_SIZE);
        send(8'h66, 0); send(8'hBB, 0);
        idle(1);
        check("rst_commit_start", bus.image_start, 1);
        check("rst_commit_bank", bus.rd_bank, 1);
        idle(3);

        g_rand_busy = 1;
        for (int k = 0; k < 6; k++) begin
            fill_random();
            send_pixels(IMAGE_SIZE);
            if ($urandom_range(0, 3) == 0) begin
                send(8'($urandom), 0); send(8'($urandom), 0);
            end else begin
                send(8'h66, 0); send(8'hBB, 0);
            end
            idle(int'($urandom_range(0, 5)));
        end
        for (int i = 0; i < 1700; i++) send(8'($urandom), int'($urandom_range(0, 1)));
        g_rand_busy = 0;
        g_busy = 0;
        idle(TMO + 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
